// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and helpers (state encoding, clks_per_bit, DEFAULT_BAUD) for the receiver and transmitter
package uart_pkg;
    localparam int DEFAULT_BAUD = 115200;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchroniser plus falling-edge detect; in sys_clk/sys_rst_n/rxd, out line (synced rxd) and start (one-cycle falling-edge pulse)
module uart_rx_sync (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic rxd,
    output logic line,
    output logic start
);
    logic s1, s2, prev;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            prev <= 1'b1;
        end else begin
            s1   <= rxd;
            s2   <= s1;
            prev <= s2;
        end
    end
    assign line  = s2;
    assign start = prev & ~s2;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 receiver (8E1/8O1 with UART_RX_PARITY_EN); in sys_clk/sys_rst_n/rxd, out rx_data, rx_valid, frame_err, parity_err, rx_busy
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = DEFAULT_BAUD,
    parameter int DATA_BITS = 8
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 rx_busy
);
    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CW  = $clog2(CPB);
    localparam int IW  = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
    if (CPB < 4) begin : g_cpb_check
        $error("uart_rx: CLKS_PER_BIT must be >= 4");
    end
    logic                 line, start;
    state_t               state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shift;
    logic                 cnt_end, cnt_mid;
    uart_rx_sync u_sync (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .rxd      (rxd),
        .line     (line),
        .start    (start)
    );
    assign cnt_end = cnt == CW'(CPB - 1);
    assign cnt_mid = cnt == CW'(CPB / 2 - 1);
    assign rx_busy = state != IDLE;
`ifdef UART_RX_PARITY_EN
    logic par;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            par        <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par        <= (state == PARITY && cnt_end) ? line : par;
            parity_err <= state == STOP && cnt_end && ((^shift ^ par) != PARITY_ODD);
        end
    end
`else
    assign parity_err = 1'b0;
`endif
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            cnt       <= (state == IDLE || state == BREAK || cnt_end) ? '0 : cnt + 1'b1;
            case (state)
                IDLE: state <= start ? START : IDLE;
                START: if (cnt_mid) begin
                    cnt   <= '0;
                    state <= line ? IDLE : DATA;
                end
                DATA: if (cnt_end) begin
                    shift <= {line, shift[DATA_BITS-1:1]};
                    idx   <= (idx == IW'(DATA_BITS - 1)) ? '0 : idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                    state <= (idx == IW'(DATA_BITS - 1)) ? PARITY : DATA;
`else
                    state <= (idx == IW'(DATA_BITS - 1)) ? STOP : DATA;
`endif
                end
`ifdef UART_RX_PARITY_EN
                PARITY: state <= cnt_end ? STOP : PARITY;
`endif
                STOP: if (cnt_end) begin
                    rx_data   <= line ? shift : rx_data;
                    rx_valid  <= line;
                    frame_err <= ~line;
                    state     <= line ? IDLE : BREAK;
                end
                BREAK: state <= line ? IDLE : BREAK;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16 clocks per bit
module tb_uart_rx;
    typedef struct {
        logic [7:0] d;
        logic       pe;
    } exp_t;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME = 16 * (10 + PB);
    localparam int LAT   = 3 + 8 + (9 + PB) * 16;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, rx_busy;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         n_valid = 0, n_ferr = 0, n_perr = 0;
    int         run = 0, max_run = 0;
    int         t_fall = 0;
    int         vcyc[$];
    exp_t       q[$];
    uart_rx #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .rx_busy   (rx_busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rst_n) begin
            run     = rx_busy ? run + 1 : 0;
            max_run = run > max_run ? run : max_run;
            if (frame_err) n_ferr++;
            if (parity_err) n_perr++;
            if (rx_valid) begin
                exp_t e;
                n_valid++;
                vcyc.push_back(cyc);
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: rx_valid with rx_data=%02h, no byte expected", rx_data);
                end else begin
                    e = q.pop_front();
                    if (rx_data !== e.d || parity_err !== e.pe) begin
                        errors++;
                        $display("FAIL sb_data: got data=%02h perr=%b, want data=%02h perr=%b", rx_data, parity_err, e.d, e.pe);
                    end
                end
            end
            if ((rx_valid && frame_err) || (parity_err && !rx_valid && !frame_err)) begin
                checks++;
                errors++;
                $display("FAIL pulse_excl: valid=%b ferr=%b perr=%b", rx_valid, frame_err, parity_err);
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par);
        #1 rxd = 1'b0;
        t_fall = cyc;
        repeat (16) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rxd = d[i];
            repeat (16) @(posedge clk);
        end
`ifdef UART_RX_PARITY_EN
        #1 rxd = ^d ^ bad_par;
        repeat (16) @(posedge clk);
`endif
        #1 rxd = stop;
        repeat (16) @(posedge clk);
    endtask
    task automatic push(input logic [7:0] d, input logic pe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        q.push_back(e);
    endtask
    task automatic test_reset;
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rx_data, rx_valid, frame_err, parity_err, rx_busy} !== 12'h0) begin
            errors++;
            $display("FAIL reset_outs: got %03h want 000", {rx_data, rx_valid, frame_err, parity_err, rx_busy});
        end
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: rx_busy=%b want 0", rx_busy);
        end
        @(posedge clk);
    endtask
    task automatic test_single;
        int nv = n_valid;
        push(8'h55, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        repeat (8) @(posedge clk);
        checks++;
        if (n_valid !== nv + 1) begin
            errors++;
            $display("FAIL single_count: got %0d pulses want 1", n_valid - nv);
        end
        checks++;
        if (vcyc.size() == 0 || vcyc[$] - t_fall !== LAT) begin
            errors++;
            $display("FAIL single_latency: got %0d want %0d", vcyc.size() ? vcyc[$] - t_fall : -1, LAT);
        end
    endtask
    task automatic test_back_to_back;
        int nv = n_valid, nf = n_ferr;
        push(8'hA3, 1'b0);
        push(8'h0F, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0);
        repeat (8) @(posedge clk);
        checks++;
        if (n_valid !== nv + 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d pulses want 2", n_valid - nv);
        end
        checks++;
        if (vcyc.size() < 2 || vcyc[$] - vcyc[$-1] !== FRAME) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d want %0d", vcyc.size() > 1 ? vcyc[$] - vcyc[$-1] : -1, FRAME);
        end
        checks++;
        if (n_ferr !== nf) begin
            errors++;
            $display("FAIL b2b_ferr: got %0d frame errors want 0", n_ferr - nf);
        end
    endtask
    task automatic test_glitch;
        int nv = n_valid, nf = n_ferr;
        max_run = 0;
        #1 rxd = 1'b0;
        repeat (5) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (40) @(posedge clk);
        checks++;
        if (max_run < 1 || max_run > 8) begin
            errors++;
            $display("FAIL glitch_busy: busy run %0d want 1..8", max_run);
        end
        checks++;
        if (n_valid !== nv || n_ferr !== nf) begin
            errors++;
            $display("FAIL glitch_pulses: got valid %0d ferr %0d want 0 0", n_valid - nv, n_ferr - nf);
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle: rx_busy=%b want 0", rx_busy);
        end
    endtask
    task automatic test_break;
        int nv = n_valid, nf = n_ferr;
        send_frame(8'hFF, 1'b0, 1'b0);
        repeat (100) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (32) @(posedge clk);
        checks++;
        if (n_ferr !== nf + 1) begin
            errors++;
            $display("FAIL break_ferr: got %0d frame errors want 1", n_ferr - nf);
        end
        checks++;
        if (rx_data !== 8'h0F || n_valid !== nv) begin
            errors++;
            $display("FAIL break_hold: got data=%02h valid=%0d want data=0f valid=0", rx_data, n_valid - nv);
        end
        push(8'h12, 1'b0);
        send_frame(8'h12, 1'b1, 1'b0);
        repeat (8) @(posedge clk);
        checks++;
        if (n_valid !== nv + 1 || rx_data !== 8'h12) begin
            errors++;
            $display("FAIL break_recover: got data=%02h valid=%0d want data=12 valid=1", rx_data, n_valid - nv);
        end
    endtask
    task automatic test_reset_midframe;
        int         nv = n_valid, nf = n_ferr;
        logic [7:0] d = 8'h3C;
        #1 rxd = 1'b0;
        repeat (16) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 rxd = d[i];
            repeat (16) @(posedge clk);
        end
        #1 rxd = d[4];
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({rx_data, rx_valid, frame_err, parity_err, rx_busy} !== 12'h0) begin
            errors++;
            $display("FAIL midrst_outs: got %03h want 000", {rx_data, rx_valid, frame_err, parity_err, rx_busy});
        end
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (200) @(posedge clk);
        checks++;
        if (n_valid !== nv || n_ferr !== nf || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort: got valid %0d ferr %0d busy %b want 0 0 0", n_valid - nv, n_ferr - nf, rx_busy);
        end
        push(8'hC4, 1'b0);
        send_frame(8'hC4, 1'b1, 1'b0);
        repeat (8) @(posedge clk);
        checks++;
        if (n_valid !== nv + 1 || rx_data !== 8'hC4) begin
            errors++;
            $display("FAIL midrst_after: got data=%02h valid=%0d want data=c4 valid=1", rx_data, n_valid - nv);
        end
    endtask
`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int nv = n_valid, np = n_perr;
        push(8'h07, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0);
        push(8'h07, 1'b1);
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (8) @(posedge clk);
        checks++;
        if (n_valid !== nv + 2 || n_perr !== np + 1) begin
            errors++;
            $display("FAIL parity_counts: got valid %0d perr %0d want 2 1", n_valid - nv, n_perr - np);
        end
    endtask
`endif
    initial begin
        @(posedge clk);
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_break;
        test_reset_midframe;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected bytes never received", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
